lock_chamber_level: RTL and testbench
=====================================

// Module: lock_chamber_level
// PURPOSE
//  Models the lock-chamber water level for the gondola lock controller. Sequences
//  filling (toward the inner/high canal level) and draining (toward the outer/low
//  level) in fixed steps on a slow tick. Drives the BCD ones/tenths digits that feed
//  the chamber seg7 pair, plus level-equal flags that gate the port-open logic.
//  Sits between the button/switch inputs and the lock system / seg7 displays.
// PARAMETERS
//  HIGH_LEVEL   80  inner canal level in tenths of a metre (8.0); range 1..99
//  LOW_LEVEL    50  outer canal level in tenths (5.0); LOW_LEVEL < HIGH_LEVEL
//  STEP          5  tenths added/removed per tick while filling/draining; >=1
// PORTS
//  clk          in   1  system clock (divided clock, as elsewhere in design)
//  reset        in   1  synchronous, active-high reset
//  tick         in   1  single-cycle level-step strobe
//  fill_btn     in   1  fill request, active-high level; rising edge detected here
//  drain_btn    in   1  drain request, active-high level; rising edge detected here
//  inner_open   in   1  inner (high-side) port open
//  outer_open   in   1  outer (low-side) port open
//  level_ones   out  4  BCD ones digit of chamber level
//  level_tenths out  4  BCD tenths digit of chamber level
//  at_high      out  1  level == HIGH_LEVEL
//  at_low       out  1  level == LOW_LEVEL
//  busy         out  1  state is FILL or DRAIN
//  fault        out  1  sticky: a port opened during FILL/DRAIN
// BEHAVIOUR
//  - Internal level register: 7-bit binary tenths; digits = level/10, level%10
//    (combinational from the register, so digits update the cycle after a step).
//  - Reset: level=LOW_LEVEL, state=IDLE, edge-detect regs=0, fault=0; outputs
//    therefore level_ones=5, level_tenths=0, at_low=1, at_high=0, busy=0.
//  - Edge detect: fill_rise = fill_btn & ~fill_q (fill_q registered each cycle);
//    same for drain. Holding a button issues exactly one request.
//  - States: IDLE, FILL, DRAIN.
//    IDLE->FILL: fill_rise & ~drain_rise & ~inner_open & ~outer_open & level<HIGH.
//    IDLE->DRAIN: drain_rise & ~fill_rise & both ports closed & level>LOW.
//    Simultaneous fill_rise and drain_rise: both ignored, stay IDLE.
//    Request with a port open, or already at target: ignored, no fault.
//    FILL: on tick, level <= min(level+STEP, HIGH_LEVEL); when the updated level
//    equals HIGH_LEVEL -> IDLE in the same cycle the final step is written.
//    DRAIN: on tick, level <= max(level-STEP, LOW_LEVEL); at LOW_LEVEL -> IDLE.
//    No step occurs on the entry cycle; first step is on the next tick after.
//    FILL/DRAIN with inner_open|outer_open -> IDLE next cycle, level frozen,
//    fault<=1. fault clears only on reset.
//    fill/drain edges while busy are ignored (no reversal mid-operation).
//  - Saturation: level never leaves [LOW_LEVEL, HIGH_LEVEL]; non-multiple
//    STEP clamps the final step.
//  - Reset mid-operation wins over tick/edges: next cycle is full reset state.
//  - at_high/at_low/busy are registered-state decodes, valid every cycle.
// TESTING
//  1 reset -> digits 5/0, at_low=1, busy=0, fault=0.
//  2 fill_btn pulse, ports closed, 6 ticks -> levels 5.5,6.0..8.0; after the 6th
//    tick busy=0, at_high=1, digits 8/0; extra ticks leave level at 8.0.
//  3 from 8.0 drain_btn held high 20 cycles + 6 ticks -> single drain to 5.0.
//  4 FILL after 2 ticks (6.0), raise outer_open -> busy=0, fault=1, level stays
//    6.0; later fill request with ports closed resumes to 8.0, fault stays 1.
//  5 fill_btn and drain_btn rise same cycle in IDLE -> no state change;
//    fill request at 8.0 or with inner_open=1 -> ignored, fault=0.
//  6 STEP=3 build: fill from 5.0 -> 5.3..7.7, then 8.0 clamp; reset asserted
//    mid-FILL with tick high -> digits 5/0, busy=0 next cycle.

Source files
------------

// File: rtl/lock_chamber_level.sv
// rtl/lock_chamber_level.sv - lock chamber water level sequencer with BCD digits and level flags
module lock_chamber_level #(
    parameter int HIGH_LEVEL = 80,
    parameter int LOW_LEVEL  = 50,
    parameter int STEP       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       fill_btn,
    input  logic       drain_btn,
    input  logic       inner_open,
    input  logic       outer_open,
    output logic [3:0] level_ones,
    output logic [3:0] level_tenths,
    output logic       at_high,
    output logic       at_low,
    output logic       busy,
    output logic       fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t     state;
    logic [6:0] level;
    logic       fill_q;
    logic       drain_q;

    logic       fill_rise;
    logic       drain_rise;
    logic       ports_open;
    logic [7:0] up_sum;
    logic [6:0] up_level;
    logic [6:0] down_level;

    assign fill_rise  = fill_btn & ~fill_q;
    assign drain_rise = drain_btn & ~drain_q;
    assign ports_open = inner_open | outer_open;

    // Next level candidates, clamped so a non-multiple step lands exactly on the target
    always_comb begin
        up_sum     = {1'b0, level} + 8'(STEP);
        up_level   = (up_sum >= 8'(HIGH_LEVEL)) ? 7'(HIGH_LEVEL) : up_sum[6:0];
        down_level = ({1'b0, level} >= 8'(LOW_LEVEL + STEP)) ? (level - 7'(STEP))
                                                            : 7'(LOW_LEVEL);
    end

    // Sequencer: button edges start an operation, ticks move the level, an open port aborts it
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            level   <= 7'(LOW_LEVEL);
            fill_q  <= 1'b0;
            drain_q <= 1'b0;
            fault   <= 1'b0;
        end else begin
            fill_q  <= fill_btn;
            drain_q <= drain_btn;
            case (state)
                IDLE: begin
                    if (fill_rise && !drain_rise && !ports_open && level < 7'(HIGH_LEVEL)) begin
                        state <= FILL;
                    end else if (drain_rise && !fill_rise && !ports_open &&
                                 level > 7'(LOW_LEVEL)) begin
                        state <= DRAIN;
                    end
                end
                FILL: begin
                    if (ports_open) begin
                        state <= IDLE;
                        fault <= 1'b1;
                    end else if (tick) begin
                        level <= up_level;
                        if (up_level == 7'(HIGH_LEVEL)) begin
                            state <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (ports_open) begin
                        state <= IDLE;
                        fault <= 1'b1;
                    end else if (tick) begin
                        level <= down_level;
                        if (down_level == 7'(LOW_LEVEL)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign level_ones   = 4'(level / 7'd10);
    assign level_tenths = 4'(level % 7'd10);
    assign at_high      = (level == 7'(HIGH_LEVEL));
    assign at_low       = (level == 7'(LOW_LEVEL));
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_lock_chamber_level.sv
// tb/tb_lock_chamber_level.sv - self-checking bench for lock_chamber_level (STEP=5 and STEP=3 instances)
module tb_lock_chamber_level;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick = 1'b0;
    logic fill_btn = 1'b0;
    logic drain_btn = 1'b0;
    logic inner_open = 1'b0;
    logic outer_open = 1'b0;

    logic [3:0] lo5, lt5, lo3, lt3;
    logic       ah5, al5, b5, f5, ah3, al3, b3, f3;

    int checks = 0;
    int errors = 0;

    // Reference model: level in tenths, mode 0=idle 1=raising 2=lowering, sticky fault
    int m_level[2];
    int m_mode[2];
    int m_fault[2];
    int m_step[2] = '{5, 3};
    logic prev_fill = 1'b0;
    logic prev_drain = 1'b0;

    lock_chamber_level #(.HIGH_LEVEL(80), .LOW_LEVEL(50), .STEP(5)) dut5 (
        .clk(clk), .reset(reset), .tick(tick), .fill_btn(fill_btn), .drain_btn(drain_btn),
        .inner_open(inner_open), .outer_open(outer_open), .level_ones(lo5),
        .level_tenths(lt5), .at_high(ah5), .at_low(al5), .busy(b5), .fault(f5)
    );

    lock_chamber_level #(.HIGH_LEVEL(80), .LOW_LEVEL(50), .STEP(3)) dut3 (
        .clk(clk), .reset(reset), .tick(tick), .fill_btn(fill_btn), .drain_btn(drain_btn),
        .inner_open(inner_open), .outer_open(outer_open), .level_ones(lo3),
        .level_tenths(lt3), .at_high(ah3), .at_low(al3), .busy(b3), .fault(f3)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] enc(int lvl, bit bsy, bit flt);
        return {4'(lvl / 10), 4'(lvl % 10), lvl == 80, lvl == 50, bsy, flt};
    endfunction

    function automatic logic [11:0] expv(int k);
        return enc(m_level[k], m_mode[k] != 0, m_fault[k] != 0);
    endfunction

    function automatic logic [11:0] obsv(int k);
        return (k == 0) ? {lo5, lt5, ah5, al5, b5, f5} : {lo3, lt3, ah3, al3, b3, f3};
    endfunction

    task automatic model_update();
        bit fr, dr, po;
        fr = fill_btn && !prev_fill;
        dr = drain_btn && !prev_drain;
        po = inner_open || outer_open;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_level[k] = 50; m_mode[k] = 0; m_fault[k] = 0;
            end else if (m_mode[k] == 0) begin
                if (fr && !dr && !po && m_level[k] < 80) m_mode[k] = 1;
                else if (dr && !fr && !po && m_level[k] > 50) m_mode[k] = 2;
            end else if (po) begin
                m_mode[k] = 0; m_fault[k] = 1;
            end else if (tick) begin
                if (m_mode[k] == 1) m_level[k] = (m_level[k] + m_step[k] > 80) ? 80 : m_level[k] + m_step[k];
                else m_level[k] = (m_level[k] - m_step[k] < 50) ? 50 : m_level[k] - m_step[k];
                if (m_level[k] == 80 || m_level[k] == 50) m_mode[k] = 0;
            end
        end
        prev_fill  = reset ? 1'b0 : fill_btn;
        prev_drain = reset ? 1'b0 : drain_btn;
    endtask

    // One clock: inputs stay stable across the edge, outputs are sampled 1 time unit later
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; tick = 1'b0; fill_btn = 1'b0; drain_btn = 1'b0;
        inner_open = 1'b0; outer_open = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obsv(k) !== enc(50, 0, 0)) begin
                errors++;
                $display("FAIL reset inst%0d got %h exp %h", k, obsv(k), enc(50, 0, 0));
            end
        end
    endtask

    task automatic test_fill();
        int exp5[6] = '{55, 60, 65, 70, 75, 80};
        do_reset();
        fill_btn = 1'b1; step(); fill_btn = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick = 1'b1; step(); tick = 1'b0;
            checks++;
            if (obsv(0) !== enc(exp5[i < 6 ? i : 5], i < 5, 0)) begin
                errors++;
                $display("FAIL fill_seq tick%0d got %h exp %h", i, obsv(0), enc(exp5[i < 6 ? i : 5], i < 5, 0));
            end
            checks++;
            if (obsv(1) !== expv(1)) begin
                errors++;
                $display("FAIL fill_step3 tick%0d got %h exp %h", i, obsv(1), expv(1));
            end
            step();
        end
    endtask

    task automatic test_drain_held();
        do_reset();
        fill_btn = 1'b1; step(); fill_btn = 1'b0;
        repeat (10) begin tick = 1'b1; step(); tick = 1'b0; step(); end
        drain_btn = 1'b1;
        repeat (20) step();
        for (int i = 0; i < 12; i++) begin
            tick = 1'b1; step(); tick = 1'b0; step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obsv(k) !== expv(k)) begin
                    errors++;
                    $display("FAIL drain_held inst%0d tick%0d got %h exp %h", k, i, obsv(k), expv(k));
                end
            end
        end
        checks++;
        if (obsv(0) !== enc(50, 0, 0)) begin
            errors++;
            $display("FAIL drain_final got %h exp %h", obsv(0), enc(50, 0, 0));
        end
        drain_btn = 1'b0; step();
    endtask

    task automatic test_fault();
        do_reset();
        fill_btn = 1'b1; step(); fill_btn = 1'b0;
        repeat (2) begin tick = 1'b1; step(); tick = 1'b0; end
        outer_open = 1'b1; step(); outer_open = 1'b0;
        checks++;
        if (obsv(0) !== enc(60, 0, 1)) begin
            errors++;
            $display("FAIL fault_abort got %h exp %h", obsv(0), enc(60, 0, 1));
        end
        repeat (3) begin tick = 1'b1; step(); tick = 1'b0; end
        checks++;
        if (obsv(0) !== enc(60, 0, 1)) begin
            errors++;
            $display("FAIL fault_frozen got %h exp %h", obsv(0), enc(60, 0, 1));
        end
        fill_btn = 1'b1; step(); fill_btn = 1'b0;
        repeat (4) begin tick = 1'b1; step(); tick = 1'b0; end
        checks++;
        if (obsv(0) !== enc(80, 0, 1)) begin
            errors++;
            $display("FAIL fault_resume got %h exp %h", obsv(0), enc(80, 0, 1));
        end
    endtask

    task automatic test_ignored();
        do_reset();
        fill_btn = 1'b1; drain_btn = 1'b1; step(); fill_btn = 1'b0; drain_btn = 1'b0;
        tick = 1'b1; step(); tick = 1'b0;
        checks++;
        if (obsv(0) !== enc(50, 0, 0)) begin
            errors++;
            $display("FAIL simultaneous got %h exp %h", obsv(0), enc(50, 0, 0));
        end
        inner_open = 1'b1; fill_btn = 1'b1; step(); fill_btn = 1'b0;
        tick = 1'b1; step(); tick = 1'b0; inner_open = 1'b0;
        checks++;
        if (obsv(0) !== enc(50, 0, 0)) begin
            errors++;
            $display("FAIL port_open_req got %h exp %h", obsv(0), enc(50, 0, 0));
        end
        fill_btn = 1'b1; step(); fill_btn = 1'b0;
        repeat (6) begin tick = 1'b1; step(); tick = 1'b0; end
        fill_btn = 1'b1; step(); fill_btn = 1'b0;
        checks++;
        if (obsv(0) !== enc(80, 0, 0)) begin
            errors++;
            $display("FAIL at_target_req got %h exp %h", obsv(0), enc(80, 0, 0));
        end
    endtask

    task automatic test_step3();
        int exp3[10] = '{53, 56, 59, 62, 65, 68, 71, 74, 77, 80};
        do_reset();
        fill_btn = 1'b1; step(); fill_btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick = 1'b1; step(); tick = 1'b0;
            checks++;
            if (obsv(1) !== enc(exp3[i], i < 9, 0)) begin
                errors++;
                $display("FAIL step3_seq tick%0d got %h exp %h", i, obsv(1), enc(exp3[i], i < 9, 0));
            end
        end
        do_reset();
        fill_btn = 1'b1; step(); fill_btn = 1'b0;
        repeat (2) begin tick = 1'b1; step(); tick = 1'b0; end
        reset = 1'b1; tick = 1'b1; step(); reset = 1'b0; tick = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obsv(k) !== enc(50, 0, 0)) begin
                errors++;
                $display("FAIL reset_mid_fill inst%0d got %h exp %h", k, obsv(k), enc(50, 0, 0));
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            fill_btn   = ($urandom_range(0, 4) == 0);
            drain_btn  = ($urandom_range(0, 4) == 0);
            tick       = ($urandom_range(0, 2) == 0);
            inner_open = ($urandom_range(0, 39) == 0);
            outer_open = ($urandom_range(0, 39) == 0);
            reset      = ($urandom_range(0, 149) == 0);
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obsv(k) !== expv(k)) begin
                    errors++;
                    $display("FAIL random inst%0d cyc%0d got %h exp %h", k, i, obsv(k), expv(k));
                end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        m_level = '{50, 50};
        m_mode  = '{0, 0};
        m_fault = '{0, 0};
        test_reset();
        test_fill();
        test_drain_held();
        test_fault();
        test_ignored();
        test_step3();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
